// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the operand/result RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    TURN = 2'd3
  } arb_state_t;

  typedef enum logic {
    ID_RD = 1'b0,
    ID_WR = 1'b1
  } req_id_t;

  function automatic arb_state_t dir_state(input req_id_t id);
    return (id == ID_RD) ? RD : WR;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signals of the port arbiter.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
    output rd_gnt, rd_valid, rd_data, wr_gnt, ram_addr, ram_wdata, ram_we, ram_re
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
    input  rd_gnt, rd_valid, rd_data, wr_gnt, ram_addr, ram_wdata, ram_we, ram_re
  );
endinterface

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the side that did not win last time goes.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_win,
  output req_id_t    pick,
  output logic       any
);

  always_comb begin
    pick = ID_RD;
    if (req == 2'b11)
      pick = (last_win == ID_WR) ? ID_RD : ID_WR;
    else if (req[ID_WR])
      pick = ID_WR;
  end

  assign any = |req;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between operand reads and result writes,
// with round-robin arbitration, direction turnaround and fixed-latency read return.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1,
  parameter int TA_CYC = 1
) (
  input logic clk,
  input logic rst,
  ram_port_arbiter_if.slave bus
);

  localparam int TW = (TA_CYC > 2) ? $clog2(TA_CYC) : 1;
  localparam logic [TW-1:0] TA_LOAD = TW'((TA_CYC > 0) ? TA_CYC - 1 : 0);

  arb_state_t        state, state_nx;
  req_id_t           last_win, last_dir, pick;
  logic              dir_vld;
  logic              any, need_turn, turn_go;
  logic              rd_win, wr_win;
  logic [TW-1:0]     ta_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [RD_LAT-1:0] vld_pipe;

  rr_pick2 u_pick (
    .req      ({bus.wr_req, bus.rd_req}),
    .last_win (last_win),
    .pick     (pick),
    .any      (any)
  );

  // dir_vld keeps the very first access after reset from paying a turnaround.
  assign need_turn = (TA_CYC > 0) && dir_vld && (pick != last_dir);

  // The cycle that detects a direction change is itself the first dead cycle;
  // TURN covers the remaining TA_CYC-1.
  always_comb begin
    state_nx = state;
    rd_win   = 1'b0;
    wr_win   = 1'b0;
    turn_go  = 1'b0;
    if (state == TURN) begin
      if (ta_cnt == TW'(1))
        state_nx = IDLE;
    end else if (!any) begin
      state_nx = IDLE;
    end else if (need_turn) begin
      turn_go  = 1'b1;
      state_nx = (TA_CYC > 1) ? TURN : IDLE;
    end else begin
      rd_win   = (pick == ID_RD);
      wr_win   = (pick == ID_WR);
      state_nx = dir_state(pick);
    end
  end

  assign bus.rd_gnt    = rd_win & ~rst;
  assign bus.wr_gnt    = wr_win & ~rst;
  assign bus.ram_re    = bus.rd_gnt;
  assign bus.ram_we    = bus.wr_gnt;
  assign bus.ram_addr  = bus.rd_gnt ? bus.rd_addr :
                         bus.wr_gnt ? bus.wr_addr : addr_q;
  assign bus.ram_wdata = bus.wr_gnt ? bus.wr_data : {DATA_W{1'b0}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_win <= ID_WR;
      last_dir <= ID_RD;
      dir_vld  <= 1'b0;
      ta_cnt   <= '0;
      addr_q   <= '0;
    end else begin
      state  <= state_nx;
      addr_q <= bus.ram_addr;
      if (turn_go) begin
        last_dir <= pick;
        ta_cnt   <= TA_LOAD;
      end else if (state == TURN) begin
        ta_cnt <= ta_cnt - 1'b1;
      end
      if (rd_win || wr_win) begin
        last_win <= pick;
        last_dir <= pick;
        dir_vld  <= 1'b1;
      end
    end
  end

  // Reset clears the pipe, so a read in flight never returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= bus.rd_gnt;
      for (int i = 1; i < RD_LAT; i++)
        vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign bus.rd_valid = vld_pipe[RD_LAT-1];
  assign bus.rd_data  = bus.rd_valid ? bus.ram_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: three arbiter configurations, each with a behavioural RAM and a read scoreboard.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]       rd_req_v = '0, wr_req_v = '0;
  logic [2:0][7:0]  rd_addr_v = '0, wr_addr_v = '0;
  logic [2:0][15:0] wr_data_v = '0;
  logic [2:0]       rd_gnt_v, wr_gnt_v, rd_valid_v, ram_re_v, ram_we_v;
  logic [2:0][15:0] rd_data_v, ram_wdata_v;
  logic [2:0][7:0]  ram_addr_v;

  int   vectors = 0, fails = 0, cyc = 0, sel = 0;
  exp_t q[$];
  logic [15:0] shadow [3][256];

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h05) ? 16'hBEEF : {8'hA5, a};
  endfunction

  function automatic int lat_of(input int s);
    return (s == 2) ? 3 : 1;
  endfunction

  // instance 0: defaults; 1: TA_CYC=0; 2: RD_LAT=3, TA_CYC=2
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int TA  = (g == 1) ? 0 : ((g == 2) ? 2 : 1);
    ram_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();
    ram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RD_LAT(LAT), .TA_CYC(TA)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    logic [15:0] mem [256];
    logic [15:0] rp  [LAT];
    initial for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      rp[0] <= bus.ram_re ? mem[bus.ram_addr] : 16'hDEAD;
      for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
    end
    assign bus.ram_rdata   = rp[LAT-1];
    assign bus.rd_req      = rd_req_v[g];
    assign bus.rd_addr     = rd_addr_v[g];
    assign bus.wr_req      = wr_req_v[g];
    assign bus.wr_addr     = wr_addr_v[g];
    assign bus.wr_data     = wr_data_v[g];
    assign rd_gnt_v[g]     = bus.rd_gnt;
    assign wr_gnt_v[g]     = bus.wr_gnt;
    assign rd_valid_v[g]   = bus.rd_valid;
    assign rd_data_v[g]    = bus.rd_data;
    assign ram_re_v[g]     = bus.ram_re;
    assign ram_we_v[g]     = bus.ram_we;
    assign ram_addr_v[g]   = bus.ram_addr;
    assign ram_wdata_v[g]  = bus.ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, scoreboard the read return, check grant and RAM strobes.
  task automatic step(input logic [1:0] exp_g, input string tag);
    logic [1:0] g;
    exp_t e;
    @(negedge clk);
    if (rd_valid_v[sel]) begin
      if (q.size() == 0) begin
        chk({tag, "/spurious_valid"}, 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk({tag, "/rdata"}, 32'(rd_data_v[sel]), 32'(e.data));
        chk({tag, "/rlat"}, 32'(cyc), 32'(e.due));
      end
    end else begin
      chk({tag, "/rdata_idle"}, 32'(rd_data_v[sel]), 32'd0);
    end
    g = {wr_gnt_v[sel], rd_gnt_v[sel]};
    chk({tag, "/gnt"}, 32'(g), 32'(exp_g));
    if (g[0]) begin
      chk({tag, "/rd_strobe"}, 32'({ram_we_v[sel], ram_re_v[sel]}), 32'd1);
      chk({tag, "/rd_addr"}, 32'(ram_addr_v[sel]), 32'(rd_addr_v[sel]));
      e.data = shadow[sel][rd_addr_v[sel]];
      e.due  = cyc + lat_of(sel);
      q.push_back(e);
    end else if (g[1]) begin
      chk({tag, "/wr_strobe"}, 32'({ram_we_v[sel], ram_re_v[sel]}), 32'd2);
      chk({tag, "/wr_addr"}, 32'(ram_addr_v[sel]), 32'(wr_addr_v[sel]));
      chk({tag, "/wr_data"}, 32'(ram_wdata_v[sel]), 32'(wr_data_v[sel]));
      shadow[sel][wr_addr_v[sel]] = wr_data_v[sel];
    end else begin
      chk({tag, "/no_strobe"}, 32'({ram_we_v[sel], ram_re_v[sel], ram_wdata_v[sel]}), 32'd0);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rd_req_v = '0;
    wr_req_v = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4; i++) step(2'b00, tag);
    chk({tag, "/queue_empty"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 3; s++)
      for (int a = 0; a < 256; a++) shadow[s][a] = init_val(8'(a));

    // reset: outputs held at 0 even with a pending read request
    rd_req_v[0]  = 1'b1;
    rd_addr_v[0] = 8'h05;
    @(negedge clk);
    chk("reset/gnt", 32'({rd_gnt_v, wr_gnt_v}), 32'd0);
    chk("reset/valid", 32'(rd_valid_v), 32'd0);
    chk("reset/strobe", 32'({ram_re_v, ram_we_v}), 32'd0);
    chk("reset/addr", 32'(ram_addr_v), 32'd0);
    chk("reset/data", 32'(rd_data_v[0]), 32'd0);
    chk("reset/wdata", 32'(ram_wdata_v[0]), 32'd0);
    rd_req_v[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: single read of RAM[5]
    sel = 0;
    rd_req_v[0] = 1'b1;
    step(2'b01, "t1_req");
    rd_req_v[0] = 1'b0;
    drain("t1");

    // 2: both requesting from reset -> alternate with one dead cycle each way
    do_reset();
    rd_addr_v[0] = 8'h07;
    wr_addr_v[0] = 8'h40;
    wr_data_v[0] = 16'h5555;
    rd_req_v[0]  = 1'b1;
    wr_req_v[0]  = 1'b1;
    for (int i = 0; i < 8; i++)
      step((i % 2 == 1) ? 2'b00 : ((i % 4 == 0) ? 2'b01 : 2'b10), $sformatf("t2_%0d", i));
    rd_req_v[0] = 1'b0;
    wr_req_v[0] = 1'b0;
    drain("t2");

    // 3: four back-to-back reads
    do_reset();
    rd_req_v[0] = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd_addr_v[0] = 8'(a);
      step(2'b01, $sformatf("t3_%0d", a));
    end
    rd_req_v[0] = 1'b0;
    drain("t3");

    // 4: write then read same address, TA_CYC=1 then TA_CYC=0
    for (int s = 0; s < 2; s++) begin
      do_reset();
      sel = s;
      wr_addr_v[s] = 8'h10;
      wr_data_v[s] = 16'h1234;
      rd_addr_v[s] = 8'h10;
      wr_req_v[s]  = 1'b1;
      step(2'b10, $sformatf("t4_%0d_wr", s));
      wr_req_v[s] = 1'b0;
      rd_req_v[s] = 1'b1;
      if (s == 0) step(2'b00, "t4_0_dead");
      step(2'b01, $sformatf("t4_%0d_rd", s));
      rd_req_v[s] = 1'b0;
      drain($sformatf("t4_%0d", s));
    end

    // 5: RD_LAT=3, reset one cycle after the grant kills the read
    do_reset();
    sel = 2;
    rd_addr_v[2] = 8'h09;
    rd_req_v[2]  = 1'b1;
    step(2'b01, "t5_req");
    rd_req_v[2] = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5/gnt", 32'({rd_gnt_v[2], wr_gnt_v[2]}), 32'd0);
    chk("t5/valid", 32'(rd_valid_v[2]), 32'd0);
    chk("t5/data", 32'(rd_data_v[2]), 32'd0);
    chk("t5/addr", 32'(ram_addr_v[2]), 32'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    drain("t5");

    // 6: write request withdrawn while blocked in TURN
    do_reset();
    rd_addr_v[2] = 8'h01;
    wr_addr_v[2] = 8'h20;
    wr_data_v[2] = 16'h7777;
    rd_req_v[2]  = 1'b1;
    step(2'b01, "t6_rd");
    rd_req_v[2] = 1'b0;
    wr_req_v[2] = 1'b1;
    step(2'b00, "t6_blocked");
    chk("t6/in_turn", 32'(u[2].dut.state), 32'(TURN));
    wr_req_v[2] = 1'b0;
    step(2'b00, "t6_dropped");
    chk("t6/idle", 32'(u[2].dut.state), 32'(IDLE));
    drain("t6");
    chk("t6/ram_kept", 32'(u[2].mem[8'h20]), 32'(init_val(8'h20)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
